// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Builds RV32 instruction words from field descriptors, flags
//             immediates that do not fit their format, and queues the words
//             behind a valid/ready interface with emit/error counters.
//  Revision : 1.0  initial release
// ============================================================================
module instr_encoder #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush_i,
  input  logic            req_v_i,
  output logic            req_rdy_o,
  input  logic [2:0]      fmt_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [4:0]      rd_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            instr_v_o,
  input  logic            instr_rdy_i,
  output logic [XLEN-1:0] instr_o,
  output logic            err_o,
  output logic [15:0]     instr_cnt_o,
  output logic [7:0]      err_cnt_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // Queue entry: {err, word}
  logic [XLEN:0]      mem_q [DEPTH];
  logic [XLEN:0]      mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [15:0]        instr_cnt_q, instr_cnt_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic [XLEN-1:0]    enc_word;
  logic               enc_legal;
  logic               imm_fits12;
  logic               imm_fits13;
  logic               imm_fits21;
  logic               full;
  logic               push;
  logic               pop;

  // Signed-range checks: every bit above the format's sign bit must match it
  assign imm_fits12 = (imm_i[XLEN-1:11] == '0) || (imm_i[XLEN-1:11] == '1);
  assign imm_fits13 = (imm_i[XLEN-1:12] == '0) || (imm_i[XLEN-1:12] == '1);
  assign imm_fits21 = (imm_i[XLEN-1:20] == '0) || (imm_i[XLEN-1:20] == '1);

  // Field packing and legality; illegal descriptors encode as an all-zero word
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (fmt_i)
      FMT_R: enc_word[31:0] = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
      FMT_I: begin
        enc_word[31:0] = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
        enc_legal      = imm_fits12;
      end
      FMT_S: begin
        enc_word[31:0] = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
        enc_legal      = imm_fits12;
      end
      FMT_B: begin
        enc_word[31:0] = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                          imm_i[4:1], imm_i[11], opcode_i};
        enc_legal      = imm_fits13 && !imm_i[0];
      end
      FMT_U: begin
        enc_word[31:0] = {imm_i[31:12], rd_i, opcode_i};
        enc_legal      = (imm_i[11:0] == 12'd0);
      end
      FMT_J: begin
        enc_word[31:0] = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        enc_legal      = imm_fits21 && !imm_i[0];
      end
      default: enc_legal = 1'b0;
    endcase
    if (!enc_legal) begin
      enc_word = '0;
    end
  end

  // Handshake: ready ignores a same-cycle pop; flush blocks both sides
  assign full      = (count_q == CNT_W'(DEPTH));
  assign req_rdy_o = !full && !flush_i;
  assign instr_v_o = (count_q != '0);
  assign push      = req_v_i && req_rdy_o;
  assign pop       = instr_v_o && instr_rdy_i && !flush_i;

  assign instr_o     = mem_q[rd_ptr_q][XLEN-1:0];
  assign err_o       = mem_q[rd_ptr_q][XLEN];
  assign instr_cnt_o = instr_cnt_q;
  assign err_cnt_o   = err_cnt_q;

  // Next-state for queue storage, pointers, occupancy and counters
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    instr_cnt_d = instr_cnt_q;
    err_cnt_d   = err_cnt_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = {!enc_legal, enc_word};
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        if (!enc_legal && (err_cnt_q != 8'hFF)) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      if (pop) begin
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
        instr_cnt_d = instr_cnt_q + 16'd1;
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State registers; asynchronous reset drops all queued entries and counts
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      instr_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      instr_cnt_q <= instr_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule
`default_nettype wire
